beta_decode_issue: RTL and testbench
====================================

Name: beta_decode_issue

Overview:
- Decode/issue stage directly upstream of the Beta ALU. It accepts 32-bit Beta instructions over a valid/ready handshake and decodes the opcode to the ALU function code FN[5:0].
- It reads the two source operands from an internal 32x32 register file, in which R31 always reads 0, and presents FN/RA/RB/WA to the ALU stage through a registered valid/ready output.
- A pending-write scoreboard stalls RAW and WAW hazards until the downstream writeback port retires the destination.

Parameters:
- DATA_W, 32, operand/register width; only 32 is supported.
- ZERO_REG, 31, register index that reads 0 and ignores writes.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST_N  in  1  asynchronous active-low reset.
- IN_VALID  in  1  instruction present.
- IN_INSTR  in  32  Beta instruction: [31:26] opcode, [25:21] Rc, [20:16] Ra, [15:11] Rb, [15:0] literal.
- IN_READY  out  1  instruction is accepted on an edge where IN_VALID && IN_READY.
- OUT_VALID  out  1  issue register holds an operation.
- OUT_READY  in  1  ALU stage consumes on an edge where OUT_VALID && OUT_READY.
- FN  out  6  ALU function code.
- RA  out  32  operand A.
- RB  out  32  operand B, either a register value or the sign-extended literal.
- WA  out  5  destination register index.
- ILLOP  out  1  issued slot is an illegal/unsupported opcode.
- WB_EN  in  1  writeback strobe.
- WB_ADDR  in  5  writeback register.
- WB_DATA  in  32  writeback value.

Behaviour:
- Reset (asynchronous, RST_N=0):
  - OUT_VALID=0, FN=0, RA=0, RB=0, WA=0, ILLOP=0.
  - Register file is all zero; pending mask is zero.
  - Reset asserted mid-operation discards the in-flight instruction and all pending bits.
- Opcode to FN decode:
  - ADD 0x20 -> 010000; SUB 0x21 -> 010001.
  - CMPEQ 0x24 -> 000011; CMPLT 0x25 -> 000101; CMPLE 0x26 -> 000111.
  - AND 0x28 -> 101000; OR 0x29 -> 101110; XOR 0x2A -> 100110; XNOR 0x2B -> 101001.
  - SHL 0x2C -> 110000; SHR 0x2D -> 110001; SRA 0x2E -> 110011.
  - Opcode+0x10 gives the constant form of the same operation: RB = sign-extended IN_INSTR[15:0] and Rb is not read.
- Illegal opcodes:
  - All other opcodes, including MUL 0x22 and DIV 0x23, issue with ILLOP=1, FN=0, RA=RB=0, WA=ZERO_REG.
  - They set no pending bit and are never stalled.
- Operand read:
  - RA = reg[Ra]; RB = reg[Rb] or the literal.
  - Index ZERO_REG always reads 0.
- Latency: one cycle from acceptance to OUT_VALID=1 with registered outputs.
- Output stability: outputs are held stable while OUT_VALID && !OUT_READY.
- Hazard:
  - hazard = pending[Ra] || (reg-form && pending[Rb]) || pending[Rc].
  - Index ZERO_REG is never pending.
- Ready:
  - IN_READY = (!OUT_VALID || OUT_READY) && !(IN_VALID && hazard).
  - IN_READY may depend combinationally on IN_INSTR.
- Scoreboard update:
  - On accept with Rc != ZERO_REG, set pending[Rc].
  - On WB_EN, write reg[WB_ADDR] = WB_DATA (ignored for ZERO_REG) and clear pending[WB_ADDR].
  - Same-cycle set and clear of the same index: the set wins.
- Same-cycle read and writeback:
  - Without the bypass feature, a read of WB_ADDR in the same cycle returns the old value; the register is still pending, so the hazard stalls it regardless.
  - The register becomes readable one cycle after the writeback.
- Back-to-back: with OUT_READY held 1 and no hazards, one instruction issues every cycle.
- Bubble: when OUT_READY=1 and nothing is accepted, OUT_VALID drops to 0 on the next edge.

Optional Feature:
- Macro: BETA_DECODE_BYPASS_EN.
- Defined:
  - A writeback in the same cycle is forwarded. WB_DATA replaces the read value when WB_EN && WB_ADDR == the source index.
  - Hazard evaluation treats pending[WB_ADDR] as already cleared in that cycle, so a dependent instruction issues on the writeback cycle.
- Undefined: no forwarding; the dependent instruction issues one cycle after the writeback (described above).

Decomposition:
- Shared package beta_pkg:
  - Opcode constants OP_ADD..OP_SRA and the CONST_OFS=0x10 offset.
  - FN constants FN_ADD, FN_SUB, FN_CMPEQ, FN_CMPLT, FN_CMPLE, FN_AND, FN_OR, FN_XOR, FN_XNOR, FN_SHL, FN_SHR, FN_SRA.
  - Instruction field slice constants.
  - Used by this block and by the ALU bench.
- One sub-module, beta_regfile: 32x32, 2 async read ports, 1 sync write port, async clear, ZERO_REG read-as-0, bypass under the macro.

Test Plan:
- Reset: R1=5, R2=3 preloaded via WB. ADD R1,R2->R3 (0x80611000) -> next cycle OUT_VALID=1, FN=010000, RA=5, RB=3, WA=3.
- Constant form: SUBC R1,-1->R4 (opcode 0x31, literal 0xFFFF) -> FN=010001, RA=5, RB=0xFFFFFFFF.
- RAW hazard: issue ADD ->R3, then AND R3,R1->R5 -> IN_READY=0 until WB_EN with WB_ADDR=3, WB_DATA=8. The AND then issues with RA=8 one cycle after the writeback, or in the same cycle under BETA_DECODE_BYPASS_EN.
- Backpressure: OUT_READY=0 for 3 cycles -> FN/RA/RB/WA held stable, IN_READY=0. Release -> the next instruction issues with no loss or duplication.
- R31 handling: WB to R31 with 0xDEADBEEF, then CMPLT R31,R31->R6 -> RA=RB=0, FN=000101, no pending bit set for R31.
- Illegal opcode: MUL (0x22) -> ILLOP=1, FN=0, WA=31. RST_N pulsed low while OUT_VALID=1 -> OUT_VALID=0 immediately and the pending mask is cleared.

Source files
------------

// File: rtl/beta_pkg.sv
// Shared Beta definitions: opcodes, ALU function codes, instruction field
// positions and the opcode decoder used by the decode/issue stage.
package beta_pkg;

  localparam int DATA_W   = 32;
  localparam int ZERO_REG = 31;
  localparam logic [4:0] ZERO_IDX = 5'(ZERO_REG);

  localparam logic [5:0] OP_ADD   = 6'h20;
  localparam logic [5:0] OP_SUB   = 6'h21;
  localparam logic [5:0] OP_CMPEQ = 6'h24;
  localparam logic [5:0] OP_CMPLT = 6'h25;
  localparam logic [5:0] OP_CMPLE = 6'h26;
  localparam logic [5:0] OP_AND   = 6'h28;
  localparam logic [5:0] OP_OR    = 6'h29;
  localparam logic [5:0] OP_XOR   = 6'h2A;
  localparam logic [5:0] OP_XNOR  = 6'h2B;
  localparam logic [5:0] OP_SHL   = 6'h2C;
  localparam logic [5:0] OP_SHR   = 6'h2D;
  localparam logic [5:0] OP_SRA   = 6'h2E;
  localparam logic [5:0] CONST_OFS = 6'h10;

  localparam logic [5:0] FN_ADD   = 6'b010000;
  localparam logic [5:0] FN_SUB   = 6'b010001;
  localparam logic [5:0] FN_CMPEQ = 6'b000011;
  localparam logic [5:0] FN_CMPLT = 6'b000101;
  localparam logic [5:0] FN_CMPLE = 6'b000111;
  localparam logic [5:0] FN_AND   = 6'b101000;
  localparam logic [5:0] FN_OR    = 6'b101110;
  localparam logic [5:0] FN_XOR   = 6'b100110;
  localparam logic [5:0] FN_XNOR  = 6'b101001;
  localparam logic [5:0] FN_SHL   = 6'b110000;
  localparam logic [5:0] FN_SHR   = 6'b110001;
  localparam logic [5:0] FN_SRA   = 6'b110011;

  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 26;
  localparam int RC_MSB  = 25;
  localparam int RC_LSB  = 21;
  localparam int RA_MSB  = 20;
  localparam int RA_LSB  = 16;
  localparam int RB_MSB  = 15;
  localparam int RB_LSB  = 11;
  localparam int LIT_MSB = 15;
  localparam int LIT_LSB = 0;

  typedef struct packed {
    logic       legal;
    logic       is_const;
    logic [5:0] fn;
  } dec_t;

  // The constant form differs from the register form only in bit 4.
  function automatic dec_t decode_op(input logic [5:0] op);
    dec_t       d;
    logic [5:0] base;
    d        = '0;
    base     = op & ~CONST_OFS;
    d.legal  = 1'b1;
    d.is_const = op[4];
    case (base)
      OP_ADD:   d.fn = FN_ADD;
      OP_SUB:   d.fn = FN_SUB;
      OP_CMPEQ: d.fn = FN_CMPEQ;
      OP_CMPLT: d.fn = FN_CMPLT;
      OP_CMPLE: d.fn = FN_CMPLE;
      OP_AND:   d.fn = FN_AND;
      OP_OR:    d.fn = FN_OR;
      OP_XOR:   d.fn = FN_XOR;
      OP_XNOR:  d.fn = FN_XNOR;
      OP_SHL:   d.fn = FN_SHL;
      OP_SHR:   d.fn = FN_SHR;
      OP_SRA:   d.fn = FN_SRA;
      default:  d = '0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/beta_decode_issue_if.sv
// Instruction, issue and writeback signals of the Beta decode/issue stage.
// slave is the stage itself, master is whatever surrounds it.
interface beta_decode_issue_if;
  import beta_pkg::*;

  logic              in_valid;
  logic [31:0]       in_instr;
  logic              in_ready;
  logic              out_valid;
  logic              out_ready;
  logic [5:0]        fn;
  logic [DATA_W-1:0] ra;
  logic [DATA_W-1:0] rb;
  logic [4:0]        wa;
  logic              illop;
  logic              wb_en;
  logic [4:0]        wb_addr;
  logic [DATA_W-1:0] wb_data;

  modport master (
    output in_valid, in_instr, out_ready, wb_en, wb_addr, wb_data,
    input  in_ready, out_valid, fn, ra, rb, wa, illop
  );

  modport slave (
    input  in_valid, in_instr, out_ready, wb_en, wb_addr, wb_data,
    output in_ready, out_valid, fn, ra, rb, wa, illop
  );

endinterface

// File: rtl/beta_regfile.sv
// 32x32 register file: two combinational read ports, one write port,
// asynchronous clear, R31 reads as zero and ignores writes.
// BETA_DECODE_BYPASS_EN: a same-cycle write is forwarded to the read ports.
module beta_regfile
  import beta_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [4:0]        rd_a_addr,
  output logic [DATA_W-1:0] rd_a_data,
  input  logic [4:0]        rd_b_addr,
  output logic [DATA_W-1:0] rd_b_data,
  input  logic              wr_en,
  input  logic [4:0]        wr_addr,
  input  logic [DATA_W-1:0] wr_data
);

  logic [DATA_W-1:0] mem [32];

  // Storage: cleared on reset, R31 is never written.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) mem[i] <= '0;
    end else if (wr_en && wr_addr != ZERO_IDX) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Read port A.
  always_comb begin
    rd_a_data = mem[rd_a_addr];
`ifdef BETA_DECODE_BYPASS_EN
    if (wr_en && wr_addr == rd_a_addr) rd_a_data = wr_data;
`endif
    if (rd_a_addr == ZERO_IDX) rd_a_data = '0;
  end

  // Read port B.
  always_comb begin
    rd_b_data = mem[rd_b_addr];
`ifdef BETA_DECODE_BYPASS_EN
    if (wr_en && wr_addr == rd_b_addr) rd_b_data = wr_data;
`endif
    if (rd_b_addr == ZERO_IDX) rd_b_data = '0;
  end

endmodule

// File: rtl/beta_decode_issue.sv
// Beta decode/issue stage: decodes opcode to ALU FN, reads operands, and
// holds a pending-write scoreboard that stalls RAW/WAW hazards until the
// writeback port retires the destination.
// BETA_DECODE_BYPASS_EN: same-cycle writeback is forwarded and clears the
// hazard in that cycle.
module beta_decode_issue
  import beta_pkg::*;
(
  input logic                clk,
  input logic                rst_n,
  beta_decode_issue_if.slave bus
);

  logic [5:0]        op;
  logic [4:0]        rc_idx, ra_idx, rb_idx;
  logic [15:0]       lit;
  dec_t              dec;
  logic [DATA_W-1:0] rd_a, rd_b, lit_sx;
  logic [31:0]       pending, pend_view, pend_nxt;
  logic              hazard, accept;

  logic              out_valid_q, illop_q;
  logic [5:0]        fn_q;
  logic [DATA_W-1:0] ra_q, rb_q;
  logic [4:0]        wa_q;

  assign op     = bus.in_instr[OPC_MSB:OPC_LSB];
  assign rc_idx = bus.in_instr[RC_MSB:RC_LSB];
  assign ra_idx = bus.in_instr[RA_MSB:RA_LSB];
  assign rb_idx = bus.in_instr[RB_MSB:RB_LSB];
  assign lit    = bus.in_instr[LIT_MSB:LIT_LSB];
  assign lit_sx = {{(DATA_W-16){lit[15]}}, lit};
  assign dec    = decode_op(op);

  beta_regfile u_regfile (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_a_addr (ra_idx),
    .rd_a_data (rd_a),
    .rd_b_addr (rb_idx),
    .rd_b_data (rd_b),
    .wr_en     (bus.wb_en),
    .wr_addr   (bus.wb_addr),
    .wr_data   (bus.wb_data)
  );

  // Pending view used for hazard checks; with bypass the retiring index is free now.
  always_comb begin
    pend_view = pending;
`ifdef BETA_DECODE_BYPASS_EN
    if (bus.wb_en) pend_view[bus.wb_addr] = 1'b0;
`endif
  end

  // Illegal opcodes write nothing and are therefore never stalled.
  assign hazard = dec.legal &&
                  (pend_view[ra_idx] || (!dec.is_const && pend_view[rb_idx]) ||
                   pend_view[rc_idx]);
  assign bus.in_ready = (!out_valid_q || bus.out_ready) && !(bus.in_valid && hazard);
  assign accept       = bus.in_valid && bus.in_ready;

  // Scoreboard next state: clear on writeback, then set on issue so a set wins.
  always_comb begin
    pend_nxt = pending;
    if (bus.wb_en) pend_nxt[bus.wb_addr] = 1'b0;
    if (accept && dec.legal && rc_idx != ZERO_IDX) pend_nxt[rc_idx] = 1'b1;
  end

  // Scoreboard register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pending <= '0;
    else        pending <= pend_nxt;
  end

  // Issue register: load on accept, drop valid when consumed with nothing behind it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      fn_q        <= '0;
      ra_q        <= '0;
      rb_q        <= '0;
      wa_q        <= '0;
      illop_q     <= 1'b0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      if (dec.legal) begin
        fn_q    <= dec.fn;
        ra_q    <= rd_a;
        rb_q    <= dec.is_const ? lit_sx : rd_b;
        wa_q    <= rc_idx;
        illop_q <= 1'b0;
      end else begin
        fn_q    <= '0;
        ra_q    <= '0;
        rb_q    <= '0;
        wa_q    <= ZERO_IDX;
        illop_q <= 1'b1;
      end
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.fn        = fn_q;
  assign bus.ra        = ra_q;
  assign bus.rb        = rb_q;
  assign bus.wa        = wa_q;
  assign bus.illop     = illop_q;

endmodule

// File: tb/tb_beta_decode_issue.sv
// Bench for beta_decode_issue: vector table, directed corner sequences and a
// randomized run against a behavioural scoreboard model.
module tb_beta_decode_issue;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  beta_decode_issue_if bus ();

  beta_decode_issue dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [31:0] instr;
    logic [5:0]  fn;
    logic [31:0] ra;
    logic [31:0] rb;
    logic [4:0]  wa;
    logic        illop;
  } vec_t;

  vec_t vt [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mkr(input logic [5:0] op, input logic [4:0] rc,
                                      input logic [4:0] ra, input logic [4:0] rb);
    return {op, rc, ra, rb, 11'b0};
  endfunction

  function automatic logic [31:0] mkc(input logic [5:0] op, input logic [4:0] rc,
                                      input logic [4:0] ra, input logic [15:0] l);
    return {op, rc, ra, l};
  endfunction

  task automatic wb(input logic [4:0] a, input logic [31:0] d);
    bus.wb_en   = 1'b1;
    bus.wb_addr = a;
    bus.wb_data = d;
    tick();
    bus.wb_en   = 1'b0;
  endtask

  // Present one instruction and hold it until accepted (bounded wait).
  task automatic issue(input logic [31:0] instr);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_instr = instr;
    #1;
    while (!bus.in_ready && n < 20) begin
      tick();
      n++;
    end
    if (!bus.in_ready) begin
      errors++;
      $display("FAIL issue_timeout: instr %08h not accepted within 20 cycles", instr);
      bus.in_valid = 1'b0;
    end else begin
      tick();
      bus.in_valid = 1'b0;
    end
  endtask

  task automatic chk_out(input string name, input logic [5:0] fn, input logic [31:0] ra,
                         input logic [31:0] rb, input logic [4:0] wa, input logic il);
    chk({name, "_valid"}, 32'(bus.out_valid), 32'd1);
    chk({name, "_fn"},    32'(bus.fn), 32'(fn));
    chk({name, "_ra"},    bus.ra, ra);
    chk({name, "_rb"},    bus.rb, rb);
    chk({name, "_wa"},    32'(bus.wa), 32'(wa));
    chk({name, "_illop"}, 32'(bus.illop), 32'(il));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Reference decode: each legal operation in both its register and constant opcode.
  task automatic ref_decode(input logic [5:0] op, output logic legal, output logic is_c,
                            output logic [5:0] fn);
    legal = 1'b1;
    is_c  = (op >= 6'h30);
    case (op)
      6'h20, 6'h30: fn = 6'b010000;
      6'h21, 6'h31: fn = 6'b010001;
      6'h24, 6'h34: fn = 6'b000011;
      6'h25, 6'h35: fn = 6'b000101;
      6'h26, 6'h36: fn = 6'b000111;
      6'h28, 6'h38: fn = 6'b101000;
      6'h29, 6'h39: fn = 6'b101110;
      6'h2A, 6'h3A: fn = 6'b100110;
      6'h2B, 6'h3B: fn = 6'b101001;
      6'h2C, 6'h3C: fn = 6'b110000;
      6'h2D, 6'h3D: fn = 6'b110001;
      6'h2E, 6'h3E: fn = 6'b110011;
      default: begin
        fn    = 6'b0;
        legal = 1'b0;
        is_c  = 1'b0;
      end
    endcase
  endtask

  function automatic logic [4:0] pick_idx();
    int r;
    r = $urandom_range(0, 8);
    return (r == 8) ? 5'd31 : 5'(r);
  endfunction

  logic [5:0] op_pool [16] = '{6'h20, 6'h21, 6'h24, 6'h25, 6'h26, 6'h28, 6'h29, 6'h2A,
                               6'h2B, 6'h2C, 6'h2D, 6'h2E, 6'h22, 6'h23, 6'h27, 6'h00};

  logic [31:0] m_reg  [32];
  logic        m_pend [32];

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_instr  = '0;
    bus.out_ready = 1'b1;
    bus.wb_en     = 1'b0;
    bus.wb_addr   = '0;
    bus.wb_data   = '0;

    vt[0]  = '{32'h80611000,                  6'b010000, 32'd5,        32'd3,        5'd3,  1'b0};
    vt[1]  = '{mkc(6'h31, 5'd4, 5'd1, 16'hFFFF),  6'b010001, 32'd5,    32'hFFFFFFFF, 5'd4,  1'b0};
    vt[2]  = '{mkr(6'h24, 5'd10, 5'd2, 5'd1),     6'b000011, 32'd3,    32'd5,        5'd10, 1'b0};
    vt[3]  = '{mkc(6'h35, 5'd11, 5'd7, 16'h7FFF), 6'b000101, 32'h80000000, 32'h00007FFF, 5'd11, 1'b0};
    vt[4]  = '{mkr(6'h26, 5'd12, 5'd8, 5'd31),    6'b000111, 32'd4,    32'd0,        5'd12, 1'b0};
    vt[5]  = '{mkr(6'h28, 5'd13, 5'd1, 5'd8),     6'b101000, 32'd5,    32'd4,        5'd13, 1'b0};
    vt[6]  = '{mkc(6'h39, 5'd14, 5'd2, 16'h8000), 6'b101110, 32'd3,    32'hFFFF8000, 5'd14, 1'b0};
    vt[7]  = '{mkr(6'h2A, 5'd15, 5'd7, 5'd1),     6'b100110, 32'h80000000, 32'd5,    5'd15, 1'b0};
    vt[8]  = '{mkc(6'h3B, 5'd16, 5'd31, 16'h1234), 6'b101001, 32'd0,   32'h00001234, 5'd16, 1'b0};
    vt[9]  = '{mkr(6'h2C, 5'd17, 5'd8, 5'd2),     6'b110000, 32'd4,    32'd3,        5'd17, 1'b0};
    vt[10] = '{mkc(6'h3D, 5'd18, 5'd7, 16'h0001), 6'b110001, 32'h80000000, 32'd1,    5'd18, 1'b0};
    vt[11] = '{mkr(6'h2E, 5'd19, 5'd1, 5'd8),     6'b110011, 32'd5,    32'd4,        5'd19, 1'b0};
    vt[12] = '{mkr(6'h22, 5'd20, 5'd1, 5'd2),     6'b000000, 32'd0,    32'd0,        5'd31, 1'b1};
    vt[13] = '{mkr(6'h23, 5'd20, 5'd1, 5'd2),     6'b000000, 32'd0,    32'd0,        5'd31, 1'b1};
    vt[14] = '{mkc(6'h3F, 5'd20, 5'd1, 16'hFFFF), 6'b000000, 32'd0,    32'd0,        5'd31, 1'b1};
    vt[15] = '{mkr(6'h27, 5'd20, 5'd1, 5'd2),     6'b000000, 32'd0,    32'd0,        5'd31, 1'b1};

    // Reset state
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_fn",        32'(bus.fn), 32'd0);
    chk("rst_ra",        bus.ra, 32'd0);
    chk("rst_rb",        bus.rb, 32'd0);
    chk("rst_wa",        32'(bus.wa), 32'd0);
    chk("rst_illop",     32'(bus.illop), 32'd0);
    rst_n = 1'b1;
    tick();

    wb(5'd1, 32'd5);
    wb(5'd2, 32'd3);
    wb(5'd7, 32'h80000000);
    wb(5'd8, 32'd4);

    // Vector table, one instruction at a time
    for (int i = 0; i < 16; i++) begin
      issue(vt[i].instr);
      chk_out($sformatf("vec%0d", i), vt[i].fn, vt[i].ra, vt[i].rb, vt[i].wa, vt[i].illop);
    end
    tick();
    wb(5'd3, 32'd0);
    wb(5'd4, 32'd0);
    for (int r = 10; r < 20; r++) wb(5'(r), 32'd0);

    // RAW hazard on R3
    issue(32'h80611000);
    bus.in_valid = 1'b1;
    bus.in_instr = mkr(6'h28, 5'd5, 5'd3, 5'd1);
    #1;
    chk("raw_stall0", 32'(bus.in_ready), 32'd0);
    tick();
    chk("raw_stall1", 32'(bus.in_ready), 32'd0);
    bus.wb_en   = 1'b1;
    bus.wb_addr = 5'd3;
    bus.wb_data = 32'd8;
    #1;
`ifdef BETA_DECODE_BYPASS_EN
    chk("raw_wb_cycle_ready", 32'(bus.in_ready), 32'd1);
    tick();
    bus.wb_en    = 1'b0;
    bus.in_valid = 1'b0;
`else
    chk("raw_wb_cycle_ready", 32'(bus.in_ready), 32'd0);
    tick();
    bus.wb_en = 1'b0;
    #1;
    chk("raw_after_wb_ready", 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
`endif
    chk_out("raw_and", 6'b101000, 32'd8, 32'd5, 5'd5, 1'b0);
    wb(5'd5, 32'd0);
    chk("bubble_valid", 32'(bus.out_valid), 32'd0);

    // Backpressure: issued slot must hold while the next one waits
    bus.out_ready = 1'b0;
    issue(mkr(6'h2A, 5'd21, 5'd1, 5'd2));
    bus.in_valid = 1'b1;
    bus.in_instr = mkr(6'h29, 5'd22, 5'd2, 5'd1);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("bp_ready%0d", k), 32'(bus.in_ready), 32'd0);
      chk_out($sformatf("bp_hold%0d", k), 6'b100110, 32'd5, 32'd3, 5'd21, 1'b0);
      tick();
    end
    bus.out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
    chk_out("bp_next", 6'b101110, 32'd3, 32'd5, 5'd22, 1'b0);
    tick();
    chk("bp_no_dup", 32'(bus.out_valid), 32'd0);

    // R31: writes ignored, never pending, back-to-back issue
    wb(5'd31, 32'hDEADBEEF);
    issue(mkr(6'h25, 5'd6, 5'd31, 5'd31));
    chk_out("r31_cmplt", 6'b000101, 32'd0, 32'd0, 5'd6, 1'b0);
    bus.in_valid = 1'b1;
    bus.in_instr = mkc(6'h30, 5'd31, 5'd31, 16'h0000);
    #1;
    chk("b2b_ready0", 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_instr = mkr(6'h20, 5'd31, 5'd31, 5'd31);
    #1;
    chk("b2b_ready1", 32'(bus.in_ready), 32'd1);
    chk_out("b2b_first", 6'b010000, 32'd0, 32'd0, 5'd31, 1'b0);
    tick();
    bus.in_valid = 1'b0;
    chk_out("b2b_second", 6'b010000, 32'd0, 32'd0, 5'd31, 1'b0);
    tick();

    // Illegal opcode, then asynchronous reset while it is in the issue slot
    issue(mkr(6'h20, 5'd23, 5'd1, 5'd2));
    issue(mkr(6'h22, 5'd24, 5'd1, 5'd2));
    chk_out("mul_illop", 6'b000000, 32'd0, 32'd0, 5'd31, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(bus.out_valid), 32'd0);
    chk("async_rst_illop", 32'(bus.illop), 32'd0);
    tick();
    rst_n = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_instr = mkr(6'h20, 5'd25, 5'd23, 5'd1);
    #1;
    chk("rst_pending_clear", 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
    chk_out("rst_regs_clear", 6'b010000, 32'd0, 32'd0, 5'd25, 1'b0);

    // Randomized run against the scoreboard model
    do_reset();
    for (int i = 0; i < 32; i++) begin
      m_reg[i]  = '0;
      m_pend[i] = 1'b0;
    end
    begin
      logic        e_valid, e_il;
      logic [5:0]  e_fn;
      logic [31:0] e_ra, e_rb;
      logic [4:0]  e_wa;
      e_valid = 1'b0;
      e_il = 1'b0; e_fn = '0; e_ra = '0; e_rb = '0; e_wa = '0;
      for (int cyc = 0; cyc < 600; cyc++) begin
        logic [5:0]  op, fn;
        logic [4:0]  rc, ra, rb;
        logic [15:0] low;
        logic        legal, is_c, hz, rdy, acc;
        logic        pe [32];
        op  = op_pool[$urandom_range(0, 15)] | (($urandom_range(0, 1) == 1) ? 6'h10 : 6'h00);
        rc  = pick_idx();
        ra  = pick_idx();
        rb  = pick_idx();
        low = 16'($urandom);
        low[15:11] = rb;
        bus.in_valid  = ($urandom_range(0, 99) < 70);
        bus.in_instr  = {op, rc, ra, low};
        bus.out_ready = ($urandom_range(0, 99) < 75);
        bus.wb_en     = ($urandom_range(0, 99) < 30);
        bus.wb_addr   = pick_idx();
        bus.wb_data   = $urandom;
        #1;
        ref_decode(op, legal, is_c, fn);
        pe = m_pend;
`ifdef BETA_DECODE_BYPASS_EN
        if (bus.wb_en) pe[bus.wb_addr] = 1'b0;
`endif
        hz  = legal && (pe[ra] || (!is_c && pe[rb]) || pe[rc]);
        rdy = (!e_valid || bus.out_ready) && !(bus.in_valid && hz);
        acc = bus.in_valid && rdy;
        chk("rnd_in_ready", 32'(bus.in_ready), 32'(rdy));
        if (acc) begin
          logic [31:0] va, vb;
          va = (ra == 5'd31) ? 32'd0 : m_reg[ra];
          vb = (rb == 5'd31) ? 32'd0 : m_reg[rb];
`ifdef BETA_DECODE_BYPASS_EN
          if (bus.wb_en && bus.wb_addr == ra && ra != 5'd31) va = bus.wb_data;
          if (bus.wb_en && bus.wb_addr == rb && rb != 5'd31) vb = bus.wb_data;
`endif
          e_valid = 1'b1;
          if (legal) begin
            e_fn = fn;
            e_ra = va;
            e_rb = is_c ? 32'($signed(low)) : vb;
            e_wa = rc;
            e_il = 1'b0;
          end else begin
            e_fn = '0; e_ra = '0; e_rb = '0; e_wa = 5'd31; e_il = 1'b1;
          end
        end else if (bus.out_ready) begin
          e_valid = 1'b0;
        end
        if (bus.wb_en) begin
          if (bus.wb_addr != 5'd31) m_reg[bus.wb_addr] = bus.wb_data;
          m_pend[bus.wb_addr] = 1'b0;
        end
        if (acc && legal && rc != 5'd31) m_pend[rc] = 1'b1;
        @(posedge clk);
        #1;
        chk("rnd_out_valid", 32'(bus.out_valid), 32'(e_valid));
        if (e_valid) begin
          chk("rnd_fn",    32'(bus.fn), 32'(e_fn));
          chk("rnd_ra",    bus.ra, e_ra);
          chk("rnd_rb",    bus.rb, e_rb);
          chk("rnd_wa",    32'(bus.wa), 32'(e_wa));
          chk("rnd_illop", 32'(bus.illop), 32'(e_il));
        end
      end
    end
    bus.in_valid = 1'b0;
    bus.wb_en    = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
